psram_qspi_controller: RTL
==========================

Name: psram_qspi_controller

Overview:
- Transaction sequencer directly upstream of the SpiBus byte engine on the Tang Nano PSRAM path.
- Runs the PSRAM power-up and QPI-entry sequence, then turns single-cycle read/write requests into byte-level sequences for the engine: command, 24-bit address, dummy and data bytes.
- Owns chip-enable framing and CE-high gaps, and returns read bursts to the requester.

Parameters:
- POWERUP_CYCLES, 4050, clocks to wait after reset before the first command (150 us at 27 MHz).
- BURST_LEN, 4, data bytes returned per read request (1..255).
- WAIT_BYTES, 3, dummy QSPI read bytes after the read address (3 bytes = 6 sclk wait cycles).
- CE_HIGH_CYCLES, 2, minimum clocks spi_ce stays high between transactions (>=1).

Ports:
- system_clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_write  in  1  1 = write one byte, 0 = read BURST_LEN bytes
- req_address  in  24  byte address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse per returned read byte
- rsp_rdata  out  8  read byte, valid with rsp_valid
- init_done  out  1  high once device is in QPI mode
- spi_ce  out  1  PSRAM chip enable, active low
- byte_start  out  1  one-cycle pulse launching a byte operation
- byte_mode  out  2  0 = SPI single-line write, 1 = QSPI write, 2 = QSPI read
- byte_tx  out  8  byte to send; held stable from byte_start until byte_done
- byte_done  in  1  one-cycle pulse: byte operation finished
- byte_rx  in  8  received byte, valid with byte_done in mode 2

Behaviour:
- Reset (async, active-high) immediately forces the following, whatever the state, including mid-transaction:
  - spi_ce=1, req_ready=0, rsp_valid=0, init_done=0, byte_start=0, byte_mode=0, byte_tx=0x00.
  - state=INIT_WAIT, counters=0.
- byte handshake:
  - Exactly one byte_start per byte; the next byte_start is issued no earlier than the cycle after byte_done.
  - spi_ce falls 1 cycle before the first byte_start of a transaction.
  - spi_ce rises the cycle after the last byte_done.
- States:
  - INIT_WAIT: count POWERUP_CYCLES -> INIT_RSTEN.
  - INIT_RSTEN: mode 0, 0x66 -> GAP.
  - INIT_RST: mode 0, 0x99 -> GAP.
  - INIT_QPI: mode 0, 0x35 -> GAP.
  - IDLE.
  - CMD -> ADDR2 -> ADDR1 -> ADDR0 (modes 1).
  - DUMMY (WAIT_BYTES x mode 2, rx discarded).
  - DATA.
  - GAP: spi_ce=1 for CE_HIGH_CYCLES, then next init step or IDLE.
- init_done rises on entry to IDLE after the INIT_QPI gap; it stays high until reset.
- req_ready=1 only in IDLE with init_done=1; it is combinational from state, so there is no bubble.
  - On accept: latch address/write/wdata, go to CMD.
  - req_ready falls the next cycle.
- Write transaction:
  - Bytes: 0x38, A[23:16], A[15:8], A[7:0], wdata (all mode 1).
  - Then GAP; no response pulse.
- Read transaction:
  - Bytes: 0xEB (mode 1), 3 address bytes (mode 1), WAIT_BYTES dummies (mode 2), BURST_LEN data bytes (mode 2).
  - Each data byte_done: rsp_valid=1 and rsp_rdata=byte_rx on the following cycle.
  - Then GAP.
- Address ordering: MSB byte first.
- Wrap: addresses are not incremented in RTL; the device wraps internally. A burst crossing a 1 KiB page is the requester's concern.
- Boundary cases:
  - byte_done outside a waiting state is ignored.
  - req_valid while busy is held off by req_ready=0.
  - Simultaneous reset and byte_done: reset wins.
  - WAIT_BYTES=0 skips DUMMY.

Optional Feature:
- PSRAM_INIT_SEQ_EN.
- Defined: full power-up sequence as above.
- Undefined:
  - The INIT_* states are removed; after reset the block enters IDLE on the first clock.
  - init_done=1 one cycle after reset release.
  - The device is expected to be in QPI mode already.

Test Plan:
- Reset release, POWERUP_CYCLES=16, CE_HIGH_CYCLES=2 -> after 16 clocks, three mode-0 bytes 0x66, 0x99, 0x35, each framed by its own spi_ce low window, >=2 high clocks between them, then init_done=1 and req_ready=1.
- Write req addr=0x123456 data=0xA5 -> byte_tx sequence 0x38, 0x12, 0x34, 0x56, 0xA5, all mode 1, single spi_ce low window, no rsp_valid.
- Read req addr=0x000010, BURST_LEN=4, WAIT_BYTES=3, engine returns 0x11, 0x22, 0x33, 0x44 -> 0xEB plus 3 address bytes, 3 mode-2 dummies, then 4 rsp_valid pulses with rdata 0x11, 0x22, 0x33, 0x44 in order.
- Back-to-back: req_valid held high across two reads -> second accept only after GAP; spi_ce high >=2 clocks between transactions.
- Reset asserted during the ADDR1 of a read -> spi_ce=1 and rsp_valid=0 in the same cycle; after release the init sequence restarts and no stale rsp_valid appears.
- Compiled without PSRAM_INIT_SEQ_EN -> init_done=1 one clock after reset release; a write issues 0x38 with no preceding 0x66/0x99/0x35.

Source files
------------

// File: rtl/psram_qspi_controller.sv
// PSRAM QSPI transaction sequencer: power-up/QPI entry, then command/address/dummy/data byte
// sequencing for the byte engine. Define PSRAM_INIT_SEQ_EN to include the power-up sequence.
module psram_qspi_controller #(
  parameter int unsigned POWERUP_CYCLES = 4050,
  parameter int unsigned BURST_LEN      = 4,
  parameter int unsigned WAIT_BYTES     = 3,
  parameter int unsigned CE_HIGH_CYCLES = 2
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        init_done,
  output logic        spi_ce,
  output logic        byte_start,
  output logic [1:0]  byte_mode,
  output logic [7:0]  byte_tx,
  input  logic        byte_done,
  input  logic [7:0]  byte_rx
);

  localparam int unsigned CntW = 16;

  typedef enum logic [3:0] {
`ifdef PSRAM_INIT_SEQ_EN
    StInitWait, StInitRsten, StInitRst, StInitQpi,
`endif
    StIdle, StCmd, StAddr2, StAddr1, StAddr0, StDummy, StData, StGap
  } state_e;

`ifdef PSRAM_INIT_SEQ_EN
  localparam state_e ResetState = StInitWait;
`else
  localparam state_e ResetState = StIdle;
`endif

  state_e            state_q, state_d, gap_next_q, gap_next_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wait_q, wait_d;   // byte_start issued, awaiting byte_done
  logic              lead_q, lead_d;   // CE-low cycle ahead of the first byte
  logic              init_done_q, init_done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_rdata_q;
  logic [23:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              write_q, write_d;
  logic              is_byte, byte_ack;

  assign init_done = init_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    gap_next_d  = gap_next_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    lead_d      = 1'b0;
    init_done_d = init_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    req_ready   = 1'b0;
    spi_ce      = 1'b1;
    byte_start  = 1'b0;
    byte_mode   = 2'd0;
    byte_tx     = 8'h00;
    is_byte     = 1'b0;
    byte_ack    = wait_q & byte_done;
    unique case (state_q)
`ifdef PSRAM_INIT_SEQ_EN
      StInitWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(POWERUP_CYCLES - 1)) begin
          state_d = StInitRsten;
          cnt_d   = '0;
          lead_d  = 1'b1;
        end
      end
      StInitRsten: begin
        is_byte = 1'b1;
        byte_tx = 8'h66;
        if (byte_ack) begin
          state_d    = StGap;
          gap_next_d = StInitRst;
        end
      end
      StInitRst: begin
        is_byte = 1'b1;
        byte_tx = 8'h99;
        if (byte_ack) begin
          state_d    = StGap;
          gap_next_d = StInitQpi;
        end
      end
      StInitQpi: begin
        is_byte = 1'b1;
        byte_tx = 8'h35;
        if (byte_ack) begin
          state_d    = StGap;
          gap_next_d = StIdle;
        end
      end
`endif
      StIdle: begin
        init_done_d = 1'b1;
        req_ready   = init_done_q;
        if (req_valid && init_done_q) begin
          addr_d  = req_address;
          wdata_d = req_wdata;
          write_d = req_write;
          state_d = StCmd;
          lead_d  = 1'b1;
        end
      end
      StCmd: begin
        is_byte   = 1'b1;
        byte_mode = 2'd1;
        byte_tx   = write_q ? 8'h38 : 8'hEB;
        if (byte_ack) state_d = StAddr2;
      end
      StAddr2: begin
        is_byte   = 1'b1;
        byte_mode = 2'd1;
        byte_tx   = addr_q[23:16];
        if (byte_ack) state_d = StAddr1;
      end
      StAddr1: begin
        is_byte   = 1'b1;
        byte_mode = 2'd1;
        byte_tx   = addr_q[15:8];
        if (byte_ack) state_d = StAddr0;
      end
      StAddr0: begin
        is_byte   = 1'b1;
        byte_mode = 2'd1;
        byte_tx   = addr_q[7:0];
        if (byte_ack) begin
          cnt_d   = '0;
          state_d = (write_q || WAIT_BYTES == 0) ? StData : StDummy;
        end
      end
      StDummy: begin
        is_byte   = 1'b1;
        byte_mode = 2'd2;
        if (byte_ack) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WAIT_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = StData;
          end
        end
      end
      StData: begin
        is_byte   = 1'b1;
        byte_mode = write_q ? 2'd1 : 2'd2;
        byte_tx   = write_q ? wdata_q : 8'h00;
        if (byte_ack) begin
          cnt_d = cnt_q + CntW'(1);
          if (write_q || cnt_q == CntW'(BURST_LEN - 1)) begin
            cnt_d      = '0;
            state_d    = StGap;
            gap_next_d = StIdle;
          end
        end
      end
      StGap: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(CE_HIGH_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = gap_next_q;
          if (gap_next_q == StIdle) init_done_d = 1'b1;
          else                      lead_d      = 1'b1;
        end
      end
      default: state_d = ResetState;
    endcase

    // Shared byte handshake for every byte-carrying state.
    if (is_byte) begin
      spi_ce = 1'b0;
      if (!wait_q && !lead_q) begin
        byte_start = 1'b1;
        wait_d     = 1'b1;
      end
      if (byte_ack) wait_d = 1'b0;
    end
    rsp_valid_d = byte_ack && (state_q == StData) && !write_q;
  end

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ResetState;
      gap_next_q  <= StIdle;
      cnt_q       <= '0;
      wait_q      <= 1'b0;
      lead_q      <= 1'b0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      addr_q      <= '0;
      wdata_q     <= 8'h00;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_next_q  <= gap_next_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      lead_q      <= lead_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= rsp_valid_d;
      if (rsp_valid_d) rsp_rdata_q <= byte_rx;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
    end
  end

endmodule
